// File: rtl/video_pattern_gen.sv
// Video source for the colour pipeline: CMOS-style frame timing plus a
// key-selectable RGB888 test pattern that switches only at frame boundaries.
module video_pattern_gen #(
    parameter int H_ACTIVE        = 640,
    parameter int H_BLANK         = 160,
    parameter int V_SYNC          = 2,
    parameter int V_BACK          = 33,
    parameter int V_ACTIVE        = 480,
    parameter int V_FRONT         = 10,
    parameter int CLKEN_DIV       = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic       post_frame_clken,
    output logic [7:0] post_img_red,
    output logic [7:0] post_img_green,
    output logic [7:0] post_img_blue
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int V_START = V_SYNC + V_BACK;
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int X_W     = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int Y_W     = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int DIV_W   = (CLKEN_DIV > 1) ? $clog2(CLKEN_DIV) : 1;
    localparam int BAR_CW  = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [X_W-1:0]    X_LAST       = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0]    X_ACT_LAST   = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0]    Y_LAST       = Y_W'(V_TOTAL - 1);
    localparam logic [Y_W-1:0]    Y_SYNC       = Y_W'(V_SYNC);
    localparam logic [Y_W-1:0]    Y_START      = Y_W'(V_START);
    localparam logic [Y_W-1:0]    Y_ACT_LAST   = Y_W'(V_START + V_ACTIVE - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST     = DIV_W'(CLKEN_DIV - 1);
    localparam logic [BAR_CW-1:0] BAR_LAST     = BAR_CW'(BAR_W - 1);
    localparam logic [DB_W-1:0]   DB_LAST      = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [DIV_W-1:0]  div_cnt;
    logic              tick;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [BAR_CW-1:0] bar_cnt;
    logic [2:0]        bar_idx;
    logic              key_s1;
    logic              key_s2;
    logic              key_db;
    logic [DB_W-1:0]   db_cnt;
    logic              db_fall;
    logic              pending;
    logic [1:0]        pattern;
    logic [7:0]        fc;
    logic              frame_start;
    logic              x_active;
    logic              vsync_c;
    logic              href_c;
    logic [7:0]        ax;
    logic [7:0]        ay;
    logic [23:0]       rgb_c;

    assign tick        = (div_cnt == DIV_LAST);
    assign frame_start = tick && (x == '0) && (y == '0);
    assign x_active    = (x <= X_ACT_LAST);
    assign vsync_c     = (y < Y_SYNC);
    assign href_c      = (y >= Y_START) && (y <= Y_ACT_LAST) && x_active;
    assign ax          = 8'(x);
    assign ay          = 8'(y - Y_START);
    assign db_fall     = key_db && !key_s2 && (db_cnt == DB_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // The bar counter tracks x across the active part of the line so the
    // bar index never needs a divide by the bar width.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x       <= '0;
            y       <= '0;
            bar_cnt <= '0;
            bar_idx <= '0;
        end else if (tick) begin
            if (x == X_LAST) begin
                x       <= '0;
                bar_cnt <= '0;
                bar_idx <= '0;
                y       <= (y == Y_LAST) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
                if (x_active) begin
                    if (bar_cnt == BAR_LAST) begin
                        bar_cnt <= '0;
                        bar_idx <= bar_idx + 1'b1;
                    end else begin
                        bar_cnt <= bar_cnt + 1'b1;
                    end
                end
            end
        end
    end

    // Any bounce back to the accepted level restarts the stability count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_s1 <= 1'b1;
            key_s2 <= 1'b1;
            key_db <= 1'b1;
            db_cnt <= '0;
        end else begin
            key_s1 <= key;
            key_s2 <= key_s1;
            if (key_s2 == key_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_cnt <= '0;
                key_db <= key_s2;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fc      <= '0;
            pattern <= '0;
            pending <= 1'b0;
        end else begin
            if (frame_start) begin
                fc <= fc + 8'd1;
                if (pending) begin
                    pattern <= pattern + 2'd1;
                end
            end
            if (db_fall) begin
                pending <= 1'b1;
            end else if (frame_start) begin
                pending <= 1'b0;
            end
        end
    end

    always_comb begin
        rgb_c = '0;
        case (pattern)
            2'd0: begin
                case (bar_idx)
                    3'd0:    rgb_c = 24'hFFFFFF;
                    3'd1:    rgb_c = 24'hFFFF00;
                    3'd2:    rgb_c = 24'h00FFFF;
                    3'd3:    rgb_c = 24'h00FF00;
                    3'd4:    rgb_c = 24'hFF00FF;
                    3'd5:    rgb_c = 24'hFF0000;
                    3'd6:    rgb_c = 24'h0000FF;
                    default: rgb_c = 24'h000000;
                endcase
            end
            2'd1:    rgb_c = {ax, ax, ax};
            2'd2:    rgb_c = (ax[3] ^ ay[3]) ? 24'hFFFFFF : 24'h000000;
            default: rgb_c = {ax + fc, ay + fc, fc};
        endcase
    end

    // Every output is registered off the same tick so they stay aligned.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            post_frame_clken <= 1'b0;
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_img_red     <= '0;
            post_img_green   <= '0;
            post_img_blue    <= '0;
        end else begin
            post_frame_clken <= tick;
            if (tick) begin
                post_frame_vsync <= vsync_c;
                post_frame_href  <= href_c;
                {post_img_red, post_img_green, post_img_blue} <= href_c ? rgb_c : 24'h000000;
            end
        end
    end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen with small frame parameters; a
// per-cycle reference of the slot position drives the expected outputs.
module tb_video_pattern_gen;

    localparam int LINE  = 20;
    localparam int FRAME = 140;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key = 1'b1;
    logic       vsync, href, clken;
    logic [7:0] red, green, blue;
    logic       vsync1, href1, clken1;
    logic [7:0] red1, green1, blue1;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   exp_pat = 0;
    bit   bench_pending = 1'b0;
    int   href_strobes = 0;
    int   href_pulses = 0;
    logic prev_href = 1'b0;

    always #5 clk = ~clk;

    video_pattern_gen #(
        .H_ACTIVE(16), .H_BLANK(4), .V_SYNC(1), .V_BACK(1), .V_ACTIVE(4),
        .V_FRONT(1), .CLKEN_DIV(2), .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key(key),
        .post_frame_vsync(vsync), .post_frame_href(href), .post_frame_clken(clken),
        .post_img_red(red), .post_img_green(green), .post_img_blue(blue)
    );

    video_pattern_gen #(
        .H_ACTIVE(16), .H_BLANK(4), .V_SYNC(1), .V_BACK(1), .V_ACTIVE(4),
        .V_FRONT(1), .CLKEN_DIV(1), .DEBOUNCE_CYCLES(4)
    ) dut_div1 (
        .clk(clk), .rst_n(rst_n), .key(1'b1),
        .post_frame_vsync(vsync1), .post_frame_href(href1), .post_frame_clken(clken1),
        .post_img_red(red1), .post_img_green(green1), .post_img_blue(blue1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h at cycle %0d", tag, obs, expv, cyc);
        end
    endtask

    function automatic logic [23:0] exp_rgb(input int pat, input int px, input int pay, input int pfc);
        logic [7:0] xb, ab, fb;
        logic [23:0] r;
        xb = 8'(px);
        ab = 8'(pay);
        fb = 8'(pfc);
        r = 24'h0;
        if (pat == 0) begin
            case (px / 2)
                0: r = 24'hFFFFFF;
                1: r = 24'hFFFF00;
                2: r = 24'h00FFFF;
                3: r = 24'h00FF00;
                4: r = 24'hFF00FF;
                5: r = 24'hFF0000;
                6: r = 24'h0000FF;
                default: r = 24'h000000;
            endcase
        end else if (pat == 1) begin
            r = {xb, xb, xb};
        end else if (pat == 2) begin
            r = (((px / 8) % 2) != ((pay / 8) % 2)) ? 24'hFFFFFF : 24'h000000;
        end else begin
            r = {xb + fb, ab + fb, fb};
        end
        return r;
    endfunction

    // One clock: advance the reference, then compare both instances.
    task automatic applyStimulus();
        bit rst_seen;
        int s, f, p, px, py, s1, p1, px1, py1;
        bit vs, hr;
        logic [26:0] exp_main;
        logic [2:0]  exp1;
        @(posedge clk);
        rst_seen = !rst_n;
        #1;
        if (rst_seen) begin
            cyc = 0;
            exp_pat = 0;
            bench_pending = 1'b0;
            href_strobes = 0;
            href_pulses = 0;
            prev_href = 1'b0;
        end else begin
            cyc++;
        end

        exp_main = '0;
        if (cyc >= 2) begin
            s  = cyc / 2 - 1;
            f  = s / FRAME;
            p  = s % FRAME;
            px = p % LINE;
            py = p / LINE;
            if (cyc % 2 == 0) begin
                if (p == 0) begin
                    if (s > 0) begin
                        checkOutput("href_strobes_per_frame", href_strobes, 64);
                        checkOutput("href_pulses_per_frame", href_pulses, 4);
                    end
                    href_strobes = 0;
                    href_pulses = 0;
                    if (bench_pending) begin
                        exp_pat = (exp_pat + 1) % 4;
                        bench_pending = 1'b0;
                    end
                end
                if (href === 1'b1) begin
                    href_strobes++;
                    if (prev_href !== 1'b1) href_pulses++;
                end
                prev_href = href;
            end
            vs = (py < 1);
            hr = (py >= 2) && (py < 6) && (px < 16);
            exp_main = {(cyc % 2 == 0), vs, hr,
                        hr ? exp_rgb(exp_pat, px, py - 2, (f + 1) % 256) : 24'h000000};
        end
        checkOutput("main_out", {5'b0, clken, vsync, href, red, green, blue}, {5'b0, exp_main});

        exp1 = '0;
        if (cyc >= 1) begin
            s1  = cyc - 1;
            p1  = s1 % FRAME;
            px1 = p1 % LINE;
            py1 = p1 / LINE;
            exp1 = {1'b1, (py1 < 1), ((py1 >= 2) && (py1 < 6) && (px1 < 16))};
        end
        checkOutput("div1_out", {29'b0, clken1, vsync1, href1}, {29'b0, exp1});
    endtask

    task automatic wait_slot(input int target);
        while (cyc < 2 * (target + 1)) applyStimulus();
    endtask

    task automatic press(input int n_low, input bit effective);
        key = 1'b0;
        repeat (n_low) applyStimulus();
        key = 1'b1;
        repeat (12) applyStimulus();
        if (effective) bench_pending = 1'b1;
    endtask

    initial begin
        repeat (3) applyStimulus();
        rst_n = 1'b1;

        wait_slot(70);
        press(2, 1'b0);
        wait_slot(FRAME + 70);
        press(10, 1'b1);
        wait_slot(2 * FRAME + 70);
        press(10, 1'b1);
        wait_slot(3 * FRAME + 70);
        press(10, 1'b1);

        // Runs the moving pattern past the fc wrap, then two presses in one
        // frame must step the pattern only once (3 -> 0).
        wait_slot(258 * FRAME + 70);
        press(10, 1'b1);
        press(10, 1'b1);

        wait_slot(259 * FRAME + 65);
        rst_n = 1'b0;
        applyStimulus();
        rst_n = 1'b1;
        wait_slot(150);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
